// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Holds the source-index width function and the packet-lock states.
package stream_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int src_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority search over the valid vector.
// Finds the first set index starting at ptr, wrapping past the top.
module rr_priority_encoder #(
    parameter int INPUTS = 4,
    parameter int PTR_W  = 2
) (
    input  logic [INPUTS-1:0] vld,
    input  logic [PTR_W-1:0]  ptr,
    output logic [PTR_W-1:0]  grant,
    output logic              any
);

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        int idx;
        grant = '0;
        any   = 1'b0;
        for (int k = INPUTS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= INPUTS) begin
                idx = idx - INPUTS;
            end
            if (vld[idx]) begin
                grant = PTR_W'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin N:1 stream arbiter with a single registered output stage.
// Define STREAM_RR_ARBITER_PKT_LOCK_EN to hold the grant for whole packets.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int INPUTS     = 4,
    localparam int SRC_W     = src_w(INPUTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS*DATA_WIDTH-1:0] din_data,
    input  logic [INPUTS-1:0]            din_last,
    input  logic [INPUTS-1:0]            din_vld,
    output logic [INPUTS-1:0]            din_rd,
    output logic [DATA_WIDTH-1:0]        dout_data,
    output logic                         dout_last,
    output logic [SRC_W-1:0]             dout_src,
    output logic                         dout_vld,
    input  logic                         dout_rd
);

    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [SRC_W-1:0]      g;
    logic                  any;
    logic [SRC_W-1:0]      sel;
    logic [SRC_W-1:0]      sel_nxt;
    logic                  sel_vld;
    logic                  can_load;
    logic                  xfer;

    logic                  vld_q, vld_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SRC_W-1:0]      src_q, src_d;

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    lock_state_e           state_q, state_d;
    logic [SRC_W-1:0]      lock_q, lock_d;
`endif

    rr_priority_encoder #(
        .INPUTS (INPUTS),
        .PTR_W  (SRC_W)
    ) u_enc (
        .vld   (din_vld),
        .ptr   (ptr_q),
        .grant (g),
        .any   (any)
    );

    // Pick the serviced requester: the free grant, or the locked one.
    always_comb begin
        sel     = g;
        sel_vld = any;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
        if (state_q == LOCKED) begin
            sel     = lock_q;
            sel_vld = din_vld[lock_q];
        end
`endif
    end

    assign can_load = !vld_q || dout_rd;
    assign xfer     = sel_vld && can_load && !rst;
    assign sel_nxt  = (sel == SRC_W'(INPUTS - 1)) ? '0 : sel + 1'b1;

    // One-hot ready toward the serviced requester only.
    always_comb begin
        din_rd = '0;
        if (xfer) begin
            din_rd[sel] = 1'b1;
        end
    end

    // Output stage: load on transfer, otherwise empty when drained.
    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        data_d = data_q;
        src_d  = src_q;
        if (xfer) begin
            vld_d  = 1'b1;
            last_d = din_last[sel];
            data_d = din_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            src_d  = sel;
        end else if (dout_rd) begin
            vld_d  = 1'b0;
        end
    end

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    // Lock onto a requester mid-packet; rotate only at its last beat.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            if (din_last[sel]) begin
                state_d = IDLE;
                ptr_d   = sel_nxt;
            end else begin
                state_d = LOCKED;
                lock_d  = sel;
            end
        end
    end
`else
    // Rotate priority past every granted beat.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = sel_nxt;
        end
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
            state_q <= IDLE;
            lock_q  <= '0;
`endif
        end else begin
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            data_q  <= data_d;
            src_q   <= src_d;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
            state_q <= state_d;
            lock_q  <= lock_d;
`endif
        end
    end

    assign dout_vld  = vld_q;
    assign dout_last = last_q;
    assign dout_data = data_q;
    assign dout_src  = src_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (4 inputs, 2-bit data).
// Expected sequences are hand-derived constants per scenario.
module tb_stream_rr_arbiter;

    localparam int DW = 2;
    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk;
    logic          rst;
    logic [N*DW-1:0] din_data;
    logic [N-1:0]  din_last;
    logic [N-1:0]  din_vld;
    logic [N-1:0]  din_rd;
    logic [DW-1:0] dout_data;
    logic          dout_last;
    logic [SW-1:0] dout_src;
    logic          dout_vld;
    logic          dout_rd;

    int n_run;
    int n_fail;
    int cnt1;
    int dtab[4] = '{0, 1, 3, 3};
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    int pkt_exp[6] = '{0, 1, 1, 1, 0, 0};
`else
    int pkt_exp[6] = '{0, 1, 0, 1, 0, 1};
`endif

    stream_rr_arbiter #(
        .DATA_WIDTH (DW),
        .INPUTS     (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_data  (din_data),
        .din_last  (din_last),
        .din_vld   (din_vld),
        .din_rd    (din_rd),
        .dout_data (dout_data),
        .dout_last (dout_last),
        .dout_src  (dout_src),
        .dout_vld  (dout_vld),
        .dout_rd   (dout_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_run    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        din_data = {2'd3, 2'd3, 2'd1, 2'd0};
        din_last = 4'b1111;
        din_vld  = 4'b1111;
        dout_rd  = 1'b1;
        tick();
        tick();

        // reset state, even with every requester valid
        chk("rst_vld", int'(dout_vld), 0);
        chk("rst_rd", int'(din_rd), 0);
        chk("rst_data", int'(dout_data), 0);
        chk("rst_last", int'(dout_last), 0);
        chk("rst_src", int'(dout_src), 0);

        // all valid: rotating 0,1,2,3,0,... one beat per cycle
        rst = 1'b0;
        #1;
        chk("rr_rd0", int'(din_rd), 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_vld", int'(dout_vld), 1);
            chk("rr_src", int'(dout_src), k % 4);
            chk("rr_data", int'(dout_data), dtab[k % 4]);
        end
        din_vld = 4'b0000;
        tick();
        chk("drain_vld", int'(dout_vld), 0);

        // single requester 2 with data 3
        din_vld = 4'b0100;
        #1;
        chk("one_rd", int'(din_rd), 4);
        tick();
        chk("one_vld", int'(dout_vld), 1);
        chk("one_src", int'(dout_src), 2);
        chk("one_data", int'(dout_data), 3);

        // ptr now 3: 1001 grants 3 then wraps to 0
        din_vld = 4'b1001;
        #1;
        chk("wrap_rd3", int'(din_rd), 8);
        tick();
        chk("wrap_src3", int'(dout_src), 3);
        chk("wrap_rd0", int'(din_rd), 1);
        tick();
        chk("wrap_src0", int'(dout_src), 0);
        din_vld = 4'b0000;
        tick();

        // backpressure: ptr 1, one beat held for 5 cycles
        din_vld = 4'b1111;
        dout_rd = 1'b0;
        #1;
        chk("bp_rd_first", int'(din_rd), 2);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rd", int'(din_rd), 0);
            chk("bp_vld", int'(dout_vld), 1);
            chk("bp_src", int'(dout_src), 1);
            chk("bp_data", int'(dout_data), 1);
            tick();
        end
        dout_rd = 1'b1;
        #1;
        chk("bp_rel_rd", int'(din_rd), 4);
        tick();
        chk("bp_nxt_src", int'(dout_src), 2);
        tick();
        chk("bp_nxt2_src", int'(dout_src), 3);
        din_vld = 4'b0000;
        tick();
        chk("bp_drain", int'(dout_vld), 0);

        // requester 1 sends a 3-beat packet, requester 0 always valid
        cnt1 = 0;
        for (int k = 0; k < 6; k++) begin
            din_vld = {2'b00, cnt1 < 3, 1'b1};
            din_last = {2'b11, cnt1 == 2, 1'b1};
            #1;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
            if (k == 2) begin
                chk("lock_rd", int'(din_rd), 2);
            end
`endif
            if (din_rd[1]) begin
                cnt1++;
            end
            tick();
            chk("pkt_src", int'(dout_src), pkt_exp[k]);
        end
        din_vld  = 4'b0000;
        din_last = 4'b1111;
        tick();

        // reset while a beat is pending and stalled
        din_vld = 4'b0001;
        dout_rd = 1'b0;
        tick();
        chk("prst_pend", int'(dout_vld), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("prst_vld", int'(dout_vld), 0);
        chk("prst_src", int'(dout_src), 0);
        din_vld = 4'b1111;
        dout_rd = 1'b1;
        #1;
        chk("prst_ptr", int'(din_rd), 1);
        tick();
        chk("prst_first", int'(dout_src), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
